// File: rtl/ann_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// ann_operand_sequencer_if
// Operand bus between the layer sequencer (master) and the neuron datapath
// (slave).
//   value, weight  : operand pair streamed once per input, zero when idle
//   bias           : bias of the neuron currently being processed
//   ann_start      : one-cycle pulse at the start of each neuron
//   ann_hidden     : layer type, constant for a whole run
//   ann_ready      : datapath result valid (from the slave)
//   ann_result     : datapath result (from the slave)
// ---------------------------------------------------------------------------
interface ann_operand_sequencer_if #(
    parameter int DW     = 8,
    parameter int DW_VEC = 8
);
    logic [DW-1:0]     value;
    logic [DW-1:0]     weight;
    logic [DW-1:0]     bias;
    logic              ann_start;
    logic              ann_hidden;
    logic              ann_ready;
    logic [DW_VEC-1:0] ann_result;

    modport master (
        output value, weight, bias, ann_start, ann_hidden,
        input  ann_ready, ann_result
    );

    modport slave (
        input  value, weight, bias, ann_start, ann_hidden,
        output ann_ready, ann_result
    );
endinterface

// File: rtl/ann_operand_sequencer.sv
// ---------------------------------------------------------------------------
// ann_operand_sequencer
// Holds one input vector plus per-neuron weights and biases written over a
// simple config bus, then runs a layer: for every neuron it pulses ann_start,
// streams N_IN value/weight pairs, waits for the datapath result and returns
// it on out_data/out_idx with an out_valid pulse. A WAIT that lasts TO_CYC
// cycles without ann_ready aborts the run with a sticky err flag.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   cfg_we/sel/addr/data : storage writes (sel 0=value, 1=weight, 2=bias),
//                       accepted only while idle
//   go, go_hidden     : start a run and its layer type (sampled while idle)
//   busy, done, err   : run status; done is a one-cycle end-of-run pulse
//   out_valid/data/idx: captured result of one neuron
//   ann               : operand bus to the datapath (master side)
// ---------------------------------------------------------------------------
module ann_operand_sequencer #(
    parameter int DW     = 8,
    parameter int DW_VEC = 8,
    parameter int N_IN   = 4,
    parameter int N_NEU  = 3,
    parameter int TO_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_sel,
    input  logic [7:0]          cfg_addr,
    input  logic [DW-1:0]       cfg_data,
    input  logic                go,
    input  logic                go_hidden,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                out_valid,
    output logic [DW_VEC-1:0]   out_data,
    output logic [7:0]          out_idx,
    ann_operand_sequencer_if.master ann
);

    localparam int NWT = N_IN * N_NEU;
    localparam int KW  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int NW  = (N_NEU > 1) ? $clog2(N_NEU) : 1;
    localparam int WIW = (NWT   > 1) ? $clog2(NWT)   : 1;
    localparam int TW  = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_t;

    // Operand storage; deliberately not touched by reset so a run can be
    // repeated after an abort without reloading.
    logic [DW-1:0] value_mem  [N_IN];
    logic [DW-1:0] weight_mem [NWT];
    logic [DW-1:0] bias_mem   [N_NEU];

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [NW-1:0]     n_q, n_d;
    logic [TW-1:0]     to_q, to_d;
    logic              err_q, err_d;
    logic              hidden_q, hidden_d;
    logic              cap_d;
    logic [DW-1:0]     value_q, weight_q, bias_q;
    logic [DW_VEC-1:0] out_data_q;
    logic [7:0]        out_idx_q;
    logic [WIW-1:0]    w_rd_idx;
    logic              cfg_ok;

    // ------------------------------------------------------------------
    // Config writes: only while idle, out-of-range entries are dropped.
    // ------------------------------------------------------------------
    assign cfg_ok = cfg_we && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            case (cfg_sel)
                2'd0: if (int'(cfg_addr) < N_IN)  value_mem[KW'(cfg_addr)]   <= cfg_data;
                2'd1: if (int'(cfg_addr) < NWT)   weight_mem[WIW'(cfg_addr)] <= cfg_data;
                2'd2: if (int'(cfg_addr) < N_NEU) bias_mem[NW'(cfg_addr)]    <= cfg_data;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        to_d     = to_q;
        err_d    = err_q;
        hidden_d = hidden_q;
        cap_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d  = S_START;
                    n_d      = '0;
                    k_d      = '0;
                    err_d    = 1'b0;
                    hidden_d = go_hidden;
                end
            end
            S_START: begin
                state_d = S_FEED;
                k_d     = '0;
            end
            S_FEED: begin
                if (k_q == KW'(N_IN - 1)) begin
                    state_d = S_WAIT;
                    k_d     = '0;
                    to_d    = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_WAIT: begin
                // ready is checked first so it wins over an expiring timeout
                if (ann.ann_ready) begin
                    state_d = S_CAPT;
                    cap_d   = 1'b1;
                end else if (to_q == TW'(TO_CYC - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_CAPT: begin
                if (n_q == NW'(N_NEU - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_START;
                    n_d     = n_q + NW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Weight entry for the next cycle; the operand registers below are the
    // registered read ports of the storage arrays, addressed with next state.
    assign w_rd_idx = WIW'(n_d) * WIW'(N_IN) + WIW'(k_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            n_q        <= '0;
            to_q       <= '0;
            err_q      <= 1'b0;
            hidden_q   <= 1'b0;
            value_q    <= '0;
            weight_q   <= '0;
            bias_q     <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            to_q     <= to_d;
            err_q    <= err_d;
            hidden_q <= hidden_d;
            value_q  <= (state_d == S_FEED) ? value_mem[k_d]       : '0;
            weight_q <= (state_d == S_FEED) ? weight_mem[w_rd_idx] : '0;
            // bias is fetched on entry to START and held through the neuron
            if (state_d == S_START) begin
                bias_q <= bias_mem[n_d];
            end
            if (cap_d) begin
                out_data_q <= ann.ann_result;
                out_idx_q  <= 8'(n_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = (state_q == S_CAPT);
    assign err       = err_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

    assign ann.value      = value_q;
    assign ann.weight     = weight_q;
    assign ann.bias       = bias_q;
    assign ann.ann_start  = (state_q == S_START);
    assign ann.ann_hidden = hidden_q;

endmodule

// File: tb/tb_ann_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ann_operand_sequencer
// Directed bench for the layer operand sequencer (N_IN=4, N_NEU=3, TO_CYC=255).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ann_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       go;
    logic       go_hidden;
    logic       busy, done, err, out_valid;
    logic [7:0] out_data, out_idx;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ann_operand_sequencer_if #(.DW(8), .DW_VEC(8)) ann_if ();

    ann_operand_sequencer #(
        .DW(8), .DW_VEC(8), .N_IN(4), .N_NEU(3), .TO_CYC(255)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .go        (go),
        .go_hidden (go_hidden),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .ann       (ann_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [7:0] addr, input logic [7:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_go(input logic hid);
        go = 1'b1; go_hidden = hid;
        tick();
        go = 1'b0; go_hidden = 1'b0;
    endtask

    // Entered while observing the neuron's START cycle; leaves observing the
    // cycle after CAPT (next START or DONE). Expected data: value[k]=k+1,
    // weight[i]=i+1, bias[n]=5+n.
    task automatic do_neuron(input int n, input logic [7:0] res, input int dly, input logic exp_h);
        check("start_pulse", ann_if.ann_start, 1);
        check("start_bias", ann_if.bias, 5 + n);
        check("start_value", ann_if.value, 0);
        check("hidden", ann_if.ann_hidden, exp_h);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("feed_value", ann_if.value, k + 1);
            check("feed_weight", ann_if.weight, n * 4 + k + 1);
            check("feed_bias", ann_if.bias, 5 + n);
        end
        tick();
        check("wait_value", ann_if.value, 0);
        check("wait_weight", ann_if.weight, 0);
        for (int i = 0; i < dly; i++) begin
            check("wait_no_valid", out_valid, 0);
            tick();
        end
        ann_if.ann_ready  = 1'b1;
        ann_if.ann_result = res;
        tick();
        ann_if.ann_ready  = 1'b0;
        ann_if.ann_result = 8'h00;
        check("capt_valid", out_valid, 1);
        check("capt_data", out_data, res);
        check("capt_idx", out_idx, n);
        tick();
        check("after_capt_valid", out_valid, 0);
        check("after_capt_data_hold", out_data, res);
    endtask

    task automatic wait_done(input int max_cyc);
        int c = 0;
        while (done !== 1'b1 && c < max_cyc) begin
            tick();
            c++;
        end
        check("done_reached", done, 1);
    endtask

    initial begin
        int bad_hid;
        int valid_seen;
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_addr = 8'd0; cfg_data = 8'd0;
        go = 1'b0; go_hidden = 1'b0;
        ann_if.ann_ready = 1'b0; ann_if.ann_result = 8'h00;

        // 1: reset state and idle with go low
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_value", ann_if.value, 0);
        check("rst_weight", ann_if.weight, 0);
        check("rst_bias", ann_if.bias, 0);
        check("rst_start", ann_if.ann_start, 0);
        check("rst_hidden", ann_if.ann_hidden, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", busy, 0);
        end

        // Load storage, plus writes that must be ignored
        for (int i = 0; i < 4; i++)  cfg_write(2'd0, 8'(i), 8'(i + 1));
        for (int i = 0; i < 12; i++) cfg_write(2'd1, 8'(i), 8'(i + 1));
        for (int i = 0; i < 3; i++)  cfg_write(2'd2, 8'(i), 8'(i + 5));
        cfg_write(2'd0, 8'd4, 8'hAA);   // out of range
        cfg_write(2'd3, 8'd0, 8'hBB);   // reserved select
        cfg_write(2'd2, 8'd3, 8'hCC);   // out of range

        // 2: full run, ready 2 cycles into WAIT
        pulse_go(1'b0);
        check("go_busy", busy, 1);
        do_neuron(0, 8'h11, 2, 1'b0);
        do_neuron(1, 8'h22, 2, 1'b0);
        do_neuron(2, 8'h33, 2, 1'b0);
        check("run2_done", done, 1);
        check("run2_done_busy", busy, 1);
        tick();
        check("run2_done_once", done, 0);
        check("run2_idle", busy, 0);
        check("run2_hold_idx", out_idx, 2);

        // 3: ready tied high, latency
        ann_if.ann_ready = 1'b1; ann_if.ann_result = 8'h5A;
        pulse_go(1'b0);                          // T+1
        check("lat_start", ann_if.ann_start, 1);
        for (int i = 0; i < 5; i++) tick();     // T+6 WAIT
        check("lat_wait_no_valid", out_valid, 0);
        tick();                                  // T+7 CAPT
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data", out_data, 8'h5A);
        check("lat_out_idx", out_idx, 0);
        tick();                                  // T+8 next START
        check("lat_next_start", ann_if.ann_start, 1);
        check("lat_next_bias", ann_if.bias, 6);
        for (int i = 0; i < 13; i++) tick();    // T+21 CAPT of neuron 2
        check("lat_last_valid", out_valid, 1);
        check("lat_last_idx", out_idx, 2);
        tick();                                  // T+22 DONE
        check("lat_done", done, 1);
        tick();
        ann_if.ann_ready = 1'b0;

        // 4: timeout
        valid_seen = 0;
        pulse_go(1'b0);
        for (int i = 0; i < 5; i++) tick();     // first WAIT cycle
        for (int i = 0; i < 254; i++) begin
            if (out_valid === 1'b1) valid_seen++;
            tick();
        end
        check("to_err_before", err, 0);
        check("to_busy_before", busy, 1);
        tick();
        check("to_done", done, 1);
        check("to_err", err, 1);
        check("to_no_valid", valid_seen + int'(out_valid), 0);
        tick();
        check("to_idle", busy, 0);
        check("to_err_sticky", err, 1);
        pulse_go(1'b0);
        check("to_err_cleared", err, 0);
        ann_if.ann_ready = 1'b1; ann_if.ann_result = 8'h77;
        wait_done(100);
        tick();

        // 5: reset during FEED of neuron 1
        pulse_go(1'b0);                          // T+1
        for (int i = 0; i < 7; i++) tick();     // T+8
        check("abort_start_n1", ann_if.ann_start, 1);
        tick(); tick();                          // T+10, FEED k=1
        check("abort_feed_weight", ann_if.weight, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ann_if.ann_ready = 1'b0; ann_if.ann_result = 8'h00;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_value", ann_if.value, 0);
        check("abort_weight", ann_if.weight, 0);
        check("abort_bias", ann_if.bias, 0);
        check("abort_start", ann_if.ann_start, 0);
        pulse_go(1'b0);
        do_neuron(0, 8'h44, 0, 1'b0);
        do_neuron(1, 8'h55, 1, 1'b0);
        do_neuron(2, 8'h66, 0, 1'b0);
        check("rerun_done", done, 1);
        tick();

        // 6: writes while busy, go in DONE, hidden layer flag
        ann_if.ann_ready = 1'b1; ann_if.ann_result = 8'h3C;
        pulse_go(1'b1);
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_addr = 8'd0; cfg_data = 8'hEE;
        bad_hid = 0;
        for (int c = 0; c < 100 && done !== 1'b1; c++) begin
            if (ann_if.ann_hidden !== 1'b1) bad_hid++;
            tick();
        end
        check("hid_done", done, 1);
        check("hid_all_run", bad_hid, 0);
        go = 1'b1;
        tick();
        go = 1'b0; cfg_we = 1'b0;
        check("go_in_done_ignored", busy, 0);
        tick();
        check("go_in_done_no_run", busy, 0);
        check("hid_held", ann_if.ann_hidden, 1);
        ann_if.ann_ready = 1'b0;
        pulse_go(1'b0);
        do_neuron(0, 8'h01, 0, 1'b0);
        do_neuron(1, 8'h02, 0, 1'b0);
        do_neuron(2, 8'h03, 0, 1'b0);
        check("final_done", done, 1);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
